// File: rtl/tetris_board_pkg.sv
// Shared types for the playfield: piece codes, board defaults, FSM states, shape masks.
// Shape mask bit 4*r+c marks cell (r,c) of the 4x4 piece box; each hex digit is one box row.
package tetris_pkg;

  localparam int COLS_DEF    = 10;
  localparam int ROWS_DEF    = 20;
  localparam int LINES_W_DEF = 16;

  localparam logic [3:0] BLK_I = 4'b1000;
  localparam logic [3:0] BLK_O = 4'b1001;
  localparam logic [3:0] BLK_T = 4'b1010;
  localparam logic [3:0] BLK_S = 4'b1011;
  localparam logic [3:0] BLK_Z = 4'b1100;
  localparam logic [3:0] BLK_J = 4'b1101;
  localparam logic [3:0] BLK_L = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_LOCK, S_SCAN} state_t;

  typedef struct packed {
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [3:0]  block;
    logic [1:0]  rot;
  } pose_t;

  // Indexed by (block - BLK_I), then rot[1:0].
  localparam logic [15:0] SHAPE_TBL [7][4] = '{
    '{16'h00F0, 16'h4444, 16'h0F00, 16'h2222},  // I
    '{16'h0066, 16'h0066, 16'h0066, 16'h0066},  // O
    '{16'h0072, 16'h0262, 16'h0270, 16'h0232},  // T
    '{16'h0036, 16'h0462, 16'h0360, 16'h0231},  // S
    '{16'h0063, 16'h0264, 16'h0630, 16'h0132},  // Z
    '{16'h0071, 16'h0226, 16'h0470, 16'h0322},  // J
    '{16'h0074, 16'h0622, 16'h0170, 16'h0223}   // L
  };

endpackage

// File: rtl/tetris_board_if.sv
// Requester/renderer bus of the playfield: pose + request pulses in, acks/status/row data out.
// master = piece controller and renderer side, slave = the board.
interface tetris_board_if #(
  parameter int COLS    = 10,
  parameter int LINES_W = 16
);
  logic [11:0]        xpos;
  logic [11:0]        ypos;
  logic [3:0]         block;
  logic [3:0]         rot;
  logic               chk_req;
  logic               lock_req;
  logic               clr;
  logic [4:0]         rd_row;
  logic               busy;
  logic               chk_ack;
  logic               chk_hit;
  logic               lock_ack;
  logic [COLS-1:0]    rd_data;
  logic [LINES_W-1:0] lines;
  logic               game_over;

  modport master (
    output xpos, ypos, block, rot, chk_req, lock_req, clr, rd_row,
    input  busy, chk_ack, chk_hit, lock_ack, rd_data, lines, game_over
  );

  modport slave (
    input  xpos, ypos, block, rot, chk_req, lock_req, clr, rd_row,
    output busy, chk_ack, chk_hit, lock_ack, rd_data, lines, game_over
  );
endinterface

// File: rtl/tetris_board_piece_mask.sv
// Combinational (block, rot) -> 16-bit occupancy mask of the 4x4 piece box; unknown codes give 0.
// Latency 0; no handshake.
module piece_mask import tetris_pkg::*; (
  input  logic [3:0]  block,
  input  logic [1:0]  rot,
  output logic [15:0] mask
);

  always_comb begin
    mask = '0;
    for (int b = 0; b < 7; b++) begin
      if (block == BLK_I + 4'(b)) mask = SHAPE_TBL[b][rot];
    end
  end

endmodule

// File: rtl/tetris_board.sv
// Playfield store: collision checks, piece lock and row clearing. Check ack 2 cycles after request,
// lock ack 22 cycles plus one per cleared row; requests arriving while busy are dropped.
module tetris_board import tetris_pkg::*; #(
  parameter int COLS    = COLS_DEF,
  parameter int ROWS    = ROWS_DEF,
  parameter int LINES_W = LINES_W_DEF
) (
  input logic           pclk,
  input logic           rst,
  tetris_board_if.slave bus
);

  state_t          state;
  pose_t           pose;
  logic [COLS-1:0] board  [ROWS];
  logic [COLS-1:0] merged [ROWS];
  logic [4:0]      scan_row;
  logic [15:0]     mask;
  logic [11:0]     cy, cx;
  logic            hit, top_write, row_full;
  logic [COLS-1:0] rd_nxt;
  logic            rot_hi_unused;

  assign rot_hi_unused = ^bus.rot[3:2];
  assign bus.busy      = (state != S_IDLE);

  piece_mask u_piece_mask (
    .block (pose.block),
    .rot   (pose.rot),
    .mask  (mask)
  );

  // Collision and merge share one pass over the box; coordinates wrap in 12 bits.
  always_comb begin
    hit       = 1'b0;
    top_write = 1'b0;
    merged    = board;
    cy        = '0;
    cx        = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        cy = pose.ypos + 12'(r);
        cx = pose.xpos + 12'(c);
        if (mask[4*r+c]) begin
          if (cy >= 12'(ROWS) || cx >= 12'(COLS)) hit = 1'b1;
          for (int br = 0; br < ROWS; br++) begin
            for (int bc = 0; bc < COLS; bc++) begin
              if (cy == 12'(br) && cx == 12'(bc)) begin
                hit              = hit | board[br][bc];
                merged[br][bc]   = 1'b1;
                if (br == 0) top_write = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    row_full = 1'b0;
    rd_nxt   = '0;
    for (int br = 0; br < ROWS; br++) begin
      if (scan_row == 5'(br)) row_full = &board[br];
      if (bus.rd_row == 5'(br)) rd_nxt = board[br];
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      pose          <= '0;
      board         <= '{default: '0};
      scan_row      <= '0;
      bus.chk_ack   <= 1'b0;
      bus.chk_hit   <= 1'b0;
      bus.lock_ack  <= 1'b0;
      bus.rd_data   <= '0;
      bus.lines     <= '0;
      bus.game_over <= 1'b0;
    end else begin
      bus.chk_ack  <= 1'b0;
      bus.lock_ack <= 1'b0;
      bus.rd_data  <= rd_nxt;
      if (bus.clr) begin
        board         <= '{default: '0};
        bus.game_over <= 1'b0;
        state         <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            pose <= '{xpos: bus.xpos, ypos: bus.ypos, block: bus.block, rot: bus.rot[1:0]};
            if (bus.lock_req)     state <= S_LOCK;
            else if (bus.chk_req) state <= S_CHECK;
          end
          S_CHECK: begin
            bus.chk_ack <= 1'b1;
            bus.chk_hit <= hit;
            state       <= S_IDLE;
          end
          S_LOCK: begin
            board    <= merged;
            if (top_write) bus.game_over <= 1'b1;
            scan_row <= 5'(ROWS - 1);
            state    <= S_SCAN;
          end
          S_SCAN: begin
            // A cleared row pulls everything above down; rescan the same row index next cycle.
            if (row_full) begin
              for (int i = 1; i < ROWS; i++) begin
                if (5'(i) <= scan_row) board[i] <= board[i-1];
              end
              board[0] <= '0;
              if (!(&bus.lines)) bus.lines <= bus.lines + 1'b1;
            end else if (scan_row == '0) begin
              bus.lock_ack <= 1'b1;
              state        <= S_IDLE;
            end else begin
              scan_row <= scan_row - 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tetris_board.sv
// Randomised and directed bench for tetris_board against a row-list model of the playfield.
module tb_tetris_board;

  logic pclk = 1'b0;
  logic rst  = 1'b1;

  tetris_board_if #(.COLS(10), .LINES_W(16)) bus ();

  tetris_board #(.COLS(10), .ROWS(20), .LINES_W(16)) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  always #5 pclk = ~pclk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Reference playfield: mdl[row], bit c = column c.
  bit [9:0] mdl [20];
  int       m_lines;
  bit       m_go;
  bit       m_hit;

  function automatic logic [15:0] shape(logic [3:0] b, logic [1:0] rt);
    logic [15:0] t [4];
    case (b)
      4'b1000: t = '{16'h00F0, 16'h4444, 16'h0F00, 16'h2222};
      4'b1001: t = '{16'h0066, 16'h0066, 16'h0066, 16'h0066};
      4'b1010: t = '{16'h0072, 16'h0262, 16'h0270, 16'h0232};
      4'b1011: t = '{16'h0036, 16'h0462, 16'h0360, 16'h0231};
      4'b1100: t = '{16'h0063, 16'h0264, 16'h0630, 16'h0132};
      4'b1101: t = '{16'h0071, 16'h0226, 16'h0470, 16'h0322};
      4'b1110: t = '{16'h0074, 16'h0622, 16'h0170, 16'h0223};
      default: t = '{default: 16'h0000};
    endcase
    return t[rt];
  endfunction

  task automatic model_clear_board();
    for (int i = 0; i < 20; i++) mdl[i] = '0;
    m_go = 1'b0;
  endtask

  // Applies one request to the model and returns the expected ack cycle (request edge = cycle 1).
  task automatic model_op(bit is_lock, logic [11:0] x, logic [11:0] y, logic [3:0] b,
                          logic [3:0] rt, output int exp_lat);
    logic [15:0] m;
    logic [11:0] cx, cy;
    bit [9:0]    keep [$];
    int          nfull;
    bit          h;
    m = shape(b, rt[1:0]);
    h = 1'b0;
    nfull = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (m[4*r+c]) begin
          cy = y + 12'(r);
          cx = x + 12'(c);
          if (cy >= 12'd20 || cx >= 12'd10) h = 1'b1;
          else begin
            if (mdl[int'(cy)][int'(cx)]) h = 1'b1;
            if (is_lock) begin
              mdl[int'(cy)][int'(cx)] = 1'b1;
              if (cy == 12'd0) m_go = 1'b1;
            end
          end
        end
      end
    end
    if (!is_lock) begin
      m_hit   = h;
      exp_lat = 2;
    end else begin
      for (int i = 0; i < 20; i++) begin
        if (mdl[i] == 10'h3FF) nfull++;
        else keep.push_back(mdl[i]);
      end
      for (int i = 0; i < 20; i++) begin
        if (i < nfull) mdl[i] = '0;
        else mdl[i] = keep[i-nfull];
      end
      m_lines = (m_lines + nfull > 65535) ? 65535 : m_lines + nfull;
      exp_lat = 22 + nfull;
    end
  endtask

  task automatic read_row(int i, output logic [9:0] d);
    @(negedge pclk);
    bus.rd_row = 5'(i);
    @(posedge pclk);
    #1;
    d = bus.rd_data;
  endtask

  task automatic verify_board(string tag);
    logic [9:0] d;
    for (int i = 0; i < 20; i++) begin
      read_row(i, d);
      check($sformatf("%s row%0d", tag, i), d, mdl[i]);
    end
    read_row(20 + $urandom_range(0, 11), d);
    check($sformatf("%s row>=20", tag), d, 0);
    check({tag, " lines"}, bus.lines, m_lines);
    check({tag, " game_over"}, bus.game_over, m_go);
  endtask

  task automatic run_op(string tag, bit is_lock, logic [11:0] x, logic [11:0] y,
                        logic [3:0] b, logic [3:0] rt, bit poke,
                        output logic seen_hit, output int seen_lat);
    int exp_lat, lat, stray;
    bit done;
    model_op(is_lock, x, y, b, rt, exp_lat);
    @(negedge pclk);
    bus.xpos = x; bus.ypos = y; bus.block = b; bus.rot = rt;
    if (is_lock) bus.lock_req = 1'b1;
    else         bus.chk_req  = 1'b1;
    @(posedge pclk);
    #1;
    bus.chk_req = 1'b0; bus.lock_req = 1'b0;
    bus.xpos = 12'($urandom); bus.ypos = 12'($urandom);
    bus.block = 4'($urandom); bus.rot = 4'($urandom);
    check({tag, " busy"}, bus.busy, 1);
    lat = 0; stray = 0; done = 1'b0; seen_hit = 1'b0;
    while (!done && lat < 100) begin
      if (poke && lat == 3) begin
        bus.chk_req = 1'b1; bus.lock_req = 1'b1;
      end
      @(posedge pclk);
      #1;
      bus.chk_req = 1'b0; bus.lock_req = 1'b0;
      lat++;
      if (is_lock ? bus.lock_ack : bus.chk_ack) begin
        done = 1'b1;
        seen_hit = bus.chk_hit;
      end
      if (is_lock ? bus.chk_ack : bus.lock_ack) stray++;
    end
    seen_lat = lat + 1;
    check({tag, " ack cycle"}, seen_lat, exp_lat);
    repeat (3) begin
      @(posedge pclk);
      #1;
      if (bus.chk_ack || bus.lock_ack) stray++;
    end
    check({tag, " stray acks"}, stray, 0);
    check({tag, " idle"}, bus.busy, 0);
    if (!is_lock) check({tag, " hit"}, seen_hit, m_hit);
    else          check({tag, " hit held"}, bus.chk_hit, m_hit);
  endtask

  task automatic do_clr();
    @(negedge pclk);
    bus.clr = 1'b1;
    @(negedge pclk);
    bus.clr = 1'b0;
    model_clear_board();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic h;
    int   lat, cnt;
    logic [9:0] d;
    logic [11:0] rx, ry;
    logic [3:0]  rb;

    bus.xpos = '0; bus.ypos = '0; bus.block = '0; bus.rot = '0;
    bus.chk_req = 1'b0; bus.lock_req = 1'b0; bus.clr = 1'b0; bus.rd_row = '0;
    for (int i = 0; i < 20; i++) mdl[i] = '0;
    m_lines = 0; m_go = 1'b0; m_hit = 1'b0;

    // Reset state
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
    #1;
    check("rst busy", bus.busy, 0);
    check("rst chk_ack", bus.chk_ack, 0);
    check("rst lock_ack", bus.lock_ack, 0);
    check("rst chk_hit", bus.chk_hit, 0);
    verify_board("rst");

    // Collision checks on an empty board (I rot0)
    run_op("chk x6", 1'b0, 12'd6, 12'd0, 4'b1000, 4'd0, 1'b0, h, lat);
    check("chk x6 hit", h, 0);
    check("chk x6 cycle", lat, 2);
    run_op("chk x7", 1'b0, 12'd7, 12'd0, 4'b1000, 4'd0, 1'b0, h, lat);
    check("chk x7 hit", h, 1);
    run_op("chk y19", 1'b0, 12'd0, 12'd19, 4'b1000, 4'd0, 1'b0, h, lat);
    check("chk y19 hit", h, 1);

    // Single lock, no clear
    run_op("lockO", 1'b1, 12'd0, 12'd18, 4'b1001, 4'd0, 1'b0, h, lat);
    check("lockO cycle", lat, 22);
    read_row(18, d); check("lockO row18", d, 10'b0000000110);
    read_row(19, d); check("lockO row19", d, 10'b0000000110);
    check("lockO lines", bus.lines, 0);

    // Completing the bottom row clears it
    do_clr();
    run_op("fillI0", 1'b1, 12'd0, 12'd18, 4'b1000, 4'd0, 1'b0, h, lat);
    run_op("fillI4", 1'b1, 12'd4, 12'd18, 4'b1000, 4'd0, 1'b0, h, lat);
    run_op("fillO7", 1'b1, 12'd7, 12'd18, 4'b1001, 4'd0, 1'b0, h, lat);
    check("clear cycle", lat, 23);
    read_row(19, d); check("clear row19", d, 10'b1100000000);
    read_row(18, d); check("clear row18", d, 10'b0000000000);
    check("clear lines", bus.lines, 1);
    verify_board("clear");

    // Game over is sticky until clr
    run_op("topO", 1'b1, 12'd4, 12'd0, 4'b1001, 4'd0, 1'b0, h, lat);
    check("top game_over", bus.game_over, 1);
    run_op("afterI", 1'b1, 12'd0, 12'd10, 4'b1000, 4'd0, 1'b0, h, lat);
    check("sticky game_over", bus.game_over, 1);
    do_clr();
    check("clr game_over", bus.game_over, 0);
    verify_board("clr");

    // Requests while busy are dropped
    run_op("poke", 1'b1, 12'd3, 12'd16, 4'b1010, 4'd1, 1'b1, h, lat);
    verify_board("poke");

    // Random poses, including wrap-around coordinates and invalid codes
    for (int n = 0; n < 40; n++) begin
      rx = ($urandom_range(0, 9) == 0) ? 12'(4093 + $urandom_range(0, 2)) : 12'($urandom_range(0, 11));
      ry = ($urandom_range(0, 4) == 0) ? 12'($urandom_range(0, 21)) : 12'($urandom_range(14, 19));
      rb = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'(8 + $urandom_range(0, 6));
      run_op($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), rx, ry, rb, 4'($urandom),
             1'($urandom_range(0, 3) == 0), h, lat);
      if (n % 4 == 3) verify_board($sformatf("rnd%0d", n));
      if (n % 13 == 12) do_clr();
    end

    // Async reset in the middle of row scanning
    @(negedge pclk);
    bus.xpos = 12'd2; bus.ypos = 12'd17; bus.block = 4'b1011; bus.rot = 4'd0;
    bus.lock_req = 1'b1;
    @(posedge pclk);
    #1;
    bus.lock_req = 1'b0;
    repeat (6) @(posedge pclk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst busy", bus.busy, 0);
    check("midrst lock_ack", bus.lock_ack, 0);
    check("midrst chk_hit", bus.chk_hit, 0);
    check("midrst lines", bus.lines, 0);
    check("midrst game_over", bus.game_over, 0);
    check("midrst rd_data", bus.rd_data, 0);
    @(negedge pclk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) mdl[i] = '0;
    m_lines = 0; m_go = 1'b0; m_hit = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(posedge pclk);
      #1;
      if (bus.lock_ack || bus.chk_ack) cnt++;
    end
    check("midrst no ack", cnt, 0);
    verify_board("midrst");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
